// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU slice.
//   op_t    : 2-bit opcode encoding (add, sub, mul, div)
//   state_t : controller states; BCD is only entered when ALU_BCD_EN is defined
//   clog2   : counter width helper, never returns less than 1
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    BCD  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Bits needed to count 0..value-1; a 1-bit counter is the minimum.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Request/response bundle between a requester (master) and alu_seq (slave).
//   start           : request, sampled by the ALU only when idle/done
//   opcode          : 00 add, 01 sub, 10 mul, 11 div
//   portA / portB   : WIDTH-bit unsigned operands
//   result          : 2*WIDTH-bit registered result
//   busy / done     : operation in flight / one-cycle completion pulse
//   neg / div_zero  : sub was negative / last div had zero divisor
//   bcd             : BCD digits of |result| (zero unless ALU_BCD_EN)
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH      = 4,
  parameter int BCD_DIGITS = 3
);

  logic                    start;
  logic [1:0]              opcode;
  logic [WIDTH-1:0]        portA;
  logic [WIDTH-1:0]        portB;
  logic [2*WIDTH-1:0]      result;
  logic                    busy;
  logic                    done;
  logic                    neg;
  logic                    div_zero;
  logic [4*BCD_DIGITS-1:0] bcd;

  modport master (
    output start, opcode, portA, portB,
    input  result, busy, done, neg, div_zero, bcd
  );

  modport slave (
    input  start, opcode, portA, portB,
    output result, busy, done, neg, div_zero, bcd
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter, one input bit per clock.
// Only compiled when ALU_BCD_EN is defined.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load value (one-cycle pulse while not converting)
//   value    : IN_W-bit binary input
//   done     : high during the cycle whose closing edge performs the last
//              shift; bcd holds the new digits from that edge onward
//   bcd      : DIGITS packed BCD digits, held between conversions
// ---------------------------------------------------------------------------
`ifdef ALU_BCD_EN
module bin2bcd_seq
  import alu_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_W-1:0]     value,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CW = clog2(IN_W);

  logic                active;
  logic [CW-1:0]       cnt;
  logic [IN_W-1:0]     shreg;
  logic [4*DIGITS-1:0] work;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] work_nx;

  // Add-3 correction on every digit that would overflow past 9 after the
  // doubling shift, then shift the next binary bit in at the bottom.
  always_comb begin
    adj = work;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
      end
    end
    work_nx = {adj[4*DIGITS-2:0], shreg[IN_W-1]};
  end

  assign done = active && (cnt == CW'(IN_W - 1));

  // The load edge performs no shift; IN_W shifting edges follow, and bcd is
  // only overwritten at the final one so the display never shows partials.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      shreg  <= '0;
      work   <= '0;
      bcd    <= '0;
    end else if (start && !active) begin
      active <= 1'b1;
      cnt    <= '0;
      shreg  <= value;
      work   <= '0;
    end else if (active) begin
      shreg <= shreg << 1;
      work  <= work_nx;
      cnt   <= cnt + CW'(1);
      if (done) begin
        bcd    <= work_nx;
        active <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Multi-cycle unsigned ALU: add/sub in one cycle, shift-add multiply and
// restoring divide in WIDTH cycles, behind a start/busy/done handshake.
// Optional macro ALU_BCD_EN adds a BCD conversion phase (2*WIDTH cycles)
// before done and drives bcd with |result|; without it bcd is tied to 0.
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : start, opcode, portA, portB in;
//                       result, busy, done, neg, div_zero, bcd out
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int BCD_DIGITS = 3
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int CW = clog2(WIDTH);
  localparam int RW = 2 * WIDTH;

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;

  logic [RW-1:0]    acc;
  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  logic [RW-1:0]    result_q;
  logic             busy_q;
  logic             done_q;
  logic             neg_q;
  logic             div_zero_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [RW-1:0]    acc_nx;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             exec_last;
  logic [RW-1:0]    final_val;
  logic             final_neg;
  logic             final_dz;

  // One EXEC step of the latched operation. exec_last marks the step that
  // produces the final value; mul and div take WIDTH steps, the rest one.
  // Divide keeps the dividend in quo and shifts quotient bits in behind it,
  // so after WIDTH steps quo is the quotient and rem the remainder.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    shifted   = {rem, quo[WIDTH-1]};
    trial     = shifted - {1'b0, b_q};
    acc_nx    = acc;
    rem_nx    = rem;
    quo_nx    = quo;
    exec_last = 1'b0;
    final_val = '0;
    final_neg = 1'b0;
    final_dz  = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_last = 1'b1;
        final_val = {{(WIDTH-1){1'b0}}, sum};
      end
      OP_SUB: begin
        exec_last = 1'b1;
        final_val = {{(WIDTH-1){diff[WIDTH]}}, diff};
        final_neg = diff[WIDTH];
      end
      OP_MUL: begin
        acc_nx    = acc + (mplier[0] ? mcand : '0);
        exec_last = (cnt == CW'(WIDTH - 1));
        final_val = acc_nx;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          exec_last = 1'b1;
          final_val = {a_q, {WIDTH{1'b1}}};
          final_dz  = 1'b1;
        end else begin
          if (trial[WIDTH]) begin
            rem_nx = shifted[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b0};
          end else begin
            rem_nx = trial[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
          end
          exec_last = (cnt == CW'(WIDTH - 1));
          final_val = {rem_nx, quo_nx};
        end
      end
      default: begin
      end
    endcase
  end

`ifdef ALU_BCD_EN
  logic          conv_start;
  logic          conv_done;
  logic [RW-1:0] conv_value;
  logic [RW-1:0] res_hold;
  logic          neg_hold;
  logic          dz_hold;

  // The converter loads on the same edge that EXEC finishes, so it sees the
  // combinational final value; a negative difference is converted as its
  // magnitude and the sign travels on neg.
  assign conv_start = (state == EXEC) && exec_last;
  assign conv_value = final_neg ? (~final_val + RW'(1)) : final_val;

  bin2bcd_seq #(
    .IN_W   (RW),
    .DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .value (conv_value),
    .done  (conv_done),
    .bcd   (bus.bcd)
  );
`else
  assign bus.bcd = {(4*BCD_DIGITS){1'b0}};
`endif

  assign bus.result   = result_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.neg      = neg_q;
  assign bus.div_zero = div_zero_q;

  // Controller and datapath registers. Operands are captured only on the
  // accepting edge, so the requester may change them freely afterwards.
  // result and flags change only on the completion edge, keeping the
  // display stable while the next operation runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      rem        <= '0;
      quo        <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef ALU_BCD_EN
      res_hold   <= '0;
      neg_hold   <= 1'b0;
      dz_hold    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            op_q       <= op_t'(bus.opcode);
            a_q        <= bus.portA;
            b_q        <= bus.portB;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= {{WIDTH{1'b0}}, bus.portA};
            mplier     <= bus.portB;
            rem        <= '0;
            quo        <= bus.portA;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          rem    <= rem_nx;
          quo    <= quo_nx;
          cnt    <= cnt + CW'(1);
          if (exec_last) begin
`ifdef ALU_BCD_EN
            res_hold <= final_val;
            neg_hold <= final_neg;
            dz_hold  <= final_dz;
            state    <= BCD;
`else
            result_q   <= final_val;
            neg_q      <= final_neg;
            div_zero_q <= final_dz;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state      <= DONE;
`endif
          end
        end
`ifdef ALU_BCD_EN
        BCD: begin
          if (conv_done) begin
            result_q   <= res_hold;
            neg_q      <= neg_hold;
            div_zero_q <= dz_hold;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state      <= DONE;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq (WIDTH=4, BCD_DIGITS=3). Expected values
// come from an arithmetic reference model of the ALU's operations.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W  = 4;
  localparam int D  = 3;
  localparam int RW = 2 * W;

`ifdef ALU_BCD_EN
  localparam int BCD_LAT = 2 * W;
  localparam bit BCD_ON  = 1'b1;
`else
  localparam int BCD_LAT = 0;
  localparam bit BCD_ON  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  alu_seq_if #(.WIDTH(W), .BCD_DIGITS(D)) bus ();

  alu_seq #(.WIDTH(W), .BCD_DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on integers for each opcode
  function automatic void ref_model(input logic [1:0] op, input int a, input int b,
                                    output logic [RW-1:0] res, output logic n,
                                    output logic dz, output int lat,
                                    output logic [4*D-1:0] bcd_e);
    int r;
    int mag;
    n   = 1'b0;
    dz  = 1'b0;
    lat = 1;
    case (op)
      2'b00: r = a + b;
      2'b01: begin r = a - b; n = (a < b); end
      2'b10: begin r = a * b; lat = W; end
      default: begin
        if (b == 0) begin
          r  = (a << W) | ((1 << W) - 1);
          dz = 1'b1;
        end else begin
          r   = ((a % b) << W) | (a / b);
          lat = W;
        end
      end
    endcase
    res   = r[RW-1:0];
    mag   = n ? (b - a) : r;
    bcd_e = '0;
    if (BCD_ON) begin
      for (int i = 0; i < D; i++) begin
        bcd_e[4*i +: 4] = 4'(mag % 10);
        mag = mag / 10;
      end
    end
    lat = lat + BCD_LAT;
  endfunction

  // Advance n cycles, ending 1 ns after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request (start high for one edge, or held high with scrambled
  // operands when hold=1), then wait a bounded time for done. lat = -1 on
  // timeout; busy_ok clears if busy dropped before done.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, output int lat, output bit busy_ok);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.portA  = a;
    bus.portB  = b;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    busy_ok = (bus.busy === 1'b1);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      if (hold) begin
        bus.opcode = 2'($urandom);
        bus.portA  = W'($urandom);
        bus.portB  = W'($urandom);
      end
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    vectors++;
    if (bus.result !== '0) begin miscompares++; $display("[TB] FAIL reset_result: got %h expected 0", bus.result); end
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    vectors++;
    if (bus.neg !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_neg: got %b expected 0", bus.neg); end
    vectors++;
    if (bus.div_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_div_zero: got %b expected 0", bus.div_zero); end
    vectors++;
    if (bus.bcd !== '0) begin miscompares++; $display("[TB] FAIL reset_bcd: got %h expected 0", bus.bcd); end
    rst = 1'b0;
    idle(1);
  endtask

  // One directed vector then nrand random vectors of one opcode
  task automatic test_opcode(input logic [1:0] op, input int da, input int db, input int nrand);
    logic [RW-1:0]  er;
    logic           en;
    logic           edz;
    int             elat;
    logic [4*D-1:0] ebcd;
    int             lat;
    bit             bok;
    for (int i = 0; i <= nrand; i++) begin
      int a;
      int b;
      a = (i == 0) ? da : int'($urandom_range(0, (1 << W) - 1));
      b = (i == 0) ? db : int'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      ref_model(op, a, b, er, en, edz, elat, ebcd);
      launch(op, W'(a), W'(b), 1'b0, lat, bok);
      vectors++;
      if (lat !== elat) begin miscompares++; $display("[TB] FAIL latency op=%0d a=%0d b=%0d: got %0d expected %0d", op, a, b, lat, elat); end
      vectors++;
      if (bus.result !== er) begin miscompares++; $display("[TB] FAIL result op=%0d a=%0d b=%0d: got %h expected %h", op, a, b, bus.result, er); end
      vectors++;
      if (bus.neg !== en) begin miscompares++; $display("[TB] FAIL neg op=%0d a=%0d b=%0d: got %b expected %b", op, a, b, bus.neg, en); end
      vectors++;
      if (bus.div_zero !== edz) begin miscompares++; $display("[TB] FAIL div_zero op=%0d a=%0d b=%0d: got %b expected %b", op, a, b, bus.div_zero, edz); end
      vectors++;
      if (bus.bcd !== ebcd) begin miscompares++; $display("[TB] FAIL bcd op=%0d a=%0d b=%0d: got %h expected %h", op, a, b, bus.bcd, ebcd); end
      vectors++;
      if (!bok) begin miscompares++; $display("[TB] FAIL busy_during op=%0d a=%0d b=%0d: got dropped expected held", op, a, b); end
      vectors++;
      if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_after op=%0d a=%0d b=%0d: got %b expected 0", op, a, b, bus.busy); end
    end
  endtask

  // Flags clear on acceptance while result stays held until completion
  task automatic test_flags_clear();
    logic [1:0]     op1 [2] = '{2'b01, 2'b11};
    int             a1  [2] = '{3, 9};
    int             b1  [2] = '{5, 0};
    logic [RW-1:0]  er;
    logic [RW-1:0]  held;
    logic           en;
    logic           edz;
    int             elat;
    logic [4*D-1:0] ebcd;
    int             lat;
    bit             bok;
    for (int i = 0; i < 2; i++) begin
      ref_model(op1[i], a1[i], b1[i], held, en, edz, elat, ebcd);
      launch(op1[i], W'(a1[i]), W'(b1[i]), 1'b0, lat, bok);
      vectors++;
      if ((bus.neg | bus.div_zero) !== 1'b1) begin miscompares++; $display("[TB] FAIL flag_set case=%0d: got neg=%b dz=%b expected one set", i, bus.neg, bus.div_zero); end
      ref_model(2'b10, 2, 3, er, en, edz, elat, ebcd);
      launch(2'b10, W'(2), W'(3), 1'b0, lat, bok);
      vectors++;
      if (lat !== elat || bus.result !== er) begin miscompares++; $display("[TB] FAIL follow_mul case=%0d: got lat=%0d res=%h expected lat=%0d res=%h", i, lat, bus.result, elat, er); end
      vectors++;
      if (bus.neg !== 1'b0 || bus.div_zero !== 1'b0) begin miscompares++; $display("[TB] FAIL flag_clear case=%0d: got neg=%b dz=%b expected 0 0", i, bus.neg, bus.div_zero); end
    end
    // Check the held value directly during the following operation
    launch(2'b01, W'(3), W'(5), 1'b0, lat, bok);
    bus.start  = 1'b1;
    bus.opcode = 2'b00;
    bus.portA  = W'(1);
    bus.portB  = W'(1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    vectors++;
    if (bus.neg !== 1'b0) begin miscompares++; $display("[TB] FAIL neg_clear_at_accept: got %b expected 0", bus.neg); end
    vectors++;
    if (bus.result !== 8'hFE) begin miscompares++; $display("[TB] FAIL result_held_in_flight: got %h expected fe", bus.result); end
    idle(1 + BCD_LAT);
    vectors++;
    if (bus.result !== 8'h02 || bus.done !== 1'b1) begin miscompares++; $display("[TB] FAIL accept_add: got res=%h done=%b expected 02 1", bus.result, bus.done); end
    held = 0;
  endtask

  // start kept high with changing operands while a mul runs is ignored
  task automatic test_busy_ignore();
    int lat;
    bit bok;
    idle(2);
    launch(2'b10, W'(15), W'(15), 1'b1, lat, bok);
    vectors++;
    if (lat !== W + BCD_LAT) begin miscompares++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, W + BCD_LAT); end
    vectors++;
    if (bus.result !== 8'hE1) begin miscompares++; $display("[TB] FAIL ignore_result: got %h expected e1", bus.result); end
    vectors++;
    if (!bok) begin miscompares++; $display("[TB] FAIL ignore_busy: got dropped expected held"); end
    idle(2);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 8'hE1) begin
      miscompares++;
      $display("[TB] FAIL ignore_after: got busy=%b done=%b res=%h expected 0 0 e1", bus.busy, bus.done, bus.result);
    end
  endtask

  // Requests issued in the DONE cycle of the previous operation
  task automatic test_back_to_back();
    logic [RW-1:0]  er;
    logic           en;
    logic           edz;
    int             elat;
    logic [4*D-1:0] ebcd;
    int             lat;
    bit             bok;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] op;
      int a;
      int b;
      op = 2'($urandom);
      a  = int'($urandom_range(0, (1 << W) - 1));
      b  = int'($urandom_range(0, (1 << W) - 1));
      ref_model(op, a, b, er, en, edz, elat, ebcd);
      launch(op, W'(a), W'(b), 1'b0, lat, bok);
      vectors++;
      if (lat !== elat || bus.result !== er || bus.neg !== en || bus.div_zero !== edz) begin
        miscompares++;
        $display("[TB] FAIL b2b op=%0d a=%0d b=%0d: got lat=%0d res=%h n=%b dz=%b expected lat=%0d res=%h n=%b dz=%b",
                 op, a, b, lat, bus.result, bus.neg, bus.div_zero, elat, er, en, edz);
      end
    end
    idle(1);
    vectors++;
    if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL done_one_cycle: got %b expected 0", bus.done); end
  endtask

  // Reset asserted two edges into a mul aborts it without a done pulse
  task automatic test_reset_midop();
    bit seen_done;
    int lat;
    bit bok;
    bus.start  = 1'b1;
    bus.opcode = 2'b10;
    bus.portA  = W'(15);
    bus.portB  = W'(15);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    idle(2);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.result !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midop_reset: got res=%h busy=%b done=%b expected 00 0 0", bus.result, bus.busy, bus.done);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | bus.done;
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | bus.done;
    end
    vectors++;
    if (seen_done !== 1'b0) begin miscompares++; $display("[TB] FAIL midop_no_done: got pulse expected none"); end
    launch(2'b00, W'(7), W'(5), 1'b0, lat, bok);
    vectors++;
    if (lat !== 1 + BCD_LAT || bus.result !== 8'h0C) begin
      miscompares++;
      $display("[TB] FAIL post_reset_add: got lat=%0d res=%h expected lat=%0d res=0c", lat, bus.result, 1 + BCD_LAT);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.opcode = 2'b00;
    bus.portA  = '0;
    bus.portB  = '0;
    test_reset();
    test_opcode(2'b00, 7, 5, 15);
    test_opcode(2'b01, 3, 5, 15);
    test_opcode(2'b10, 15, 15, 15);
    test_opcode(2'b11, 13, 4, 15);
    test_opcode(2'b11, 9, 0, 5);
    test_flags_clear();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
